// File: rtl/cdp_rdma_reg_pkg.sv
// Shared definitions for the CDP RDMA register groups: status codes and group types.
// Imported by the group-enable slice, the controller and the single-register slice.
package cdp_rdma_reg_pkg;

  typedef logic       grp_idx_t;
  typedef logic [1:0] grp_status_t;

  localparam grp_status_t IDLE_CODE = 2'd0;
  localparam grp_status_t RUN_CODE  = 2'd1;
  localparam grp_status_t PEND_CODE = 2'd2;

  localparam int unsigned NUM_GROUPS = 2;

  // A disabled group is IDLE whether or not hardware currently points at it.
  function automatic grp_status_t encode_status(input logic op_en, input logic is_consumer);
    grp_status_t s;
    s = IDLE_CODE;
    if (op_en) begin
      s = is_consumer ? RUN_CODE : PEND_CODE;
    end
    return s;
  endfunction

endpackage

// File: rtl/cdp_rdma_grp_en.sv
// One register group's op_enable flop: set by a software write of 1, cleared by hardware done.
// Clear wins over set, so a write-1 that lands on the completing edge leaves the group disabled.
module cdp_rdma_grp_en
  import cdp_rdma_reg_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_set,
  input  logic        i_clr,
  input  logic        i_is_consumer,
  output logic        o_op_en,
  output grp_status_t o_status
);

  logic r_op_en;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op_en <= 1'b0;
    end else if (i_clr) begin
      r_op_en <= 1'b0;
    end else if (i_set) begin
      r_op_en <= 1'b1;
    end
  end

  assign o_op_en  = r_op_en;
  assign o_status = encode_status(r_op_en, i_is_consumer);

endmodule

// File: rtl/cdp_rdma_reg_group_ctrl.sv
// Ping-pong register-group controller for the CDP read DMA: tracks the consumer pointer,
// drives op_en/op_load toward the datapath and raises per-group done interrupts.
module cdp_rdma_reg_group_ctrl
  import cdp_rdma_reg_pkg::*;
(
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        producer,
  input  logic        op_en_wr_en,
  input  logic        op_en_wr_data,
  input  logic        op_done,
  output logic        consumer,
  output logic [1:0]  status_0,
  output logic [1:0]  status_1,
  output logic        d0_op_en,
  output logic        d1_op_en,
  output logic        op_en,
  output logic        op_load,
  output logic [1:0]  done_intr,
  output logic        err_spurious_done
);

  // Handshake: op_en is a level "valid" meaning the datapath may run on group `consumer`;
  // op_load pulses on its first cycle; op_done is the one-cycle completion, honoured only
  // while op_en=1. op_en then drops for at least one cycle before the next operation.

  grp_idx_t    r_consumer;
  logic        r_op_en;
  logic        r_op_load;
  logic [1:0]  r_done_intr;
  logic        r_err_spurious;

  logic [1:0]  w_set;
  logic [1:0]  w_clr;
  logic [1:0]  w_d_op_en;
  grp_status_t w_status [NUM_GROUPS];
  logic        w_done;
  logic        w_op_en_nxt;

  assign w_done = op_done & r_op_en;

  always_comb begin
    w_set = 2'b00;
    w_clr = 2'b00;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      w_set[g] = op_en_wr_en & op_en_wr_data & (producer == grp_idx_t'(g));
      w_clr[g] = w_done & (r_consumer == grp_idx_t'(g));
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_GROUPS; gi++) begin : g_grp
      cdp_rdma_grp_en u_grp_en (
        .i_clk         (nvdla_core_clk),
        .i_rst         (nvdla_core_rst),
        .i_set         (w_set[gi]),
        .i_clr         (w_clr[gi]),
        .i_is_consumer (r_consumer == grp_idx_t'(gi)),
        .o_op_en       (w_d_op_en[gi]),
        .o_status      (w_status[gi])
      );
    end
  endgenerate

  // Raw op_done (even a spurious one) masks op_en for that edge, guaranteeing the gap.
  assign w_op_en_nxt = w_d_op_en[r_consumer] & ~op_done;

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_consumer     <= 1'b0;
      r_op_en        <= 1'b0;
      r_op_load      <= 1'b0;
      r_done_intr    <= 2'b00;
      r_err_spurious <= 1'b0;
    end else begin
      r_op_en     <= w_op_en_nxt;
      r_op_load   <= w_op_en_nxt & ~r_op_en;
      r_done_intr <= w_done ? {r_consumer, ~r_consumer} : 2'b00;
      if (w_done) begin
        r_consumer <= ~r_consumer;
      end
      if (op_done & ~r_op_en) begin
        r_err_spurious <= 1'b1;
      end
    end
  end

  assign consumer          = r_consumer;
  assign status_0          = w_status[0];
  assign status_1          = w_status[1];
  assign d0_op_en          = w_d_op_en[0];
  assign d1_op_en          = w_d_op_en[1];
  assign op_en             = r_op_en;
  assign op_load           = r_op_load;
  assign done_intr         = r_done_intr;
  assign err_spurious_done = r_err_spurious;

endmodule

// File: tb/tb_cdp_rdma_reg_group_ctrl.sv
// Directed bench for the ping-pong register-group controller with hand-computed expectations.
module tb_cdp_rdma_reg_group_ctrl;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PEND = 2'd2;

  logic       clk;
  logic       rst;
  logic       producer;
  logic       op_en_wr_en;
  logic       op_en_wr_data;
  logic       op_done;
  logic       consumer;
  logic [1:0] status_0;
  logic [1:0] status_1;
  logic       d0_op_en;
  logic       d1_op_en;
  logic       op_en;
  logic       op_load;
  logic [1:0] done_intr;
  logic       err_spurious_done;

  int n_cmp;
  int n_err;

  cdp_rdma_reg_group_ctrl dut (
    .nvdla_core_clk    (clk),
    .nvdla_core_rst    (rst),
    .producer          (producer),
    .op_en_wr_en       (op_en_wr_en),
    .op_en_wr_data     (op_en_wr_data),
    .op_done           (op_done),
    .consumer          (consumer),
    .status_0          (status_0),
    .status_1          (status_1),
    .d0_op_en          (d0_op_en),
    .d1_op_en          (d1_op_en),
    .op_en             (op_en),
    .op_load           (op_load),
    .done_intr         (done_intr),
    .err_spurious_done (err_spurious_done)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // advance to 1ns after the next rising edge; inputs driven here hold for a full cycle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    op_en_wr_en   = 1'b0;
    op_en_wr_data = 1'b0;
    op_done       = 1'b0;
  endtask

  task automatic drive_write(input logic grp, input logic data);
    producer      = grp;
    op_en_wr_en   = 1'b1;
    op_en_wr_data = data;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_consumer"}, 32'(consumer), 32'd0);
    check_eq({tag, "_d0"}, 32'(d0_op_en), 32'd0);
    check_eq({tag, "_d1"}, 32'(d1_op_en), 32'd0);
    check_eq({tag, "_op_en"}, 32'(op_en), 32'd0);
    check_eq({tag, "_op_load"}, 32'(op_load), 32'd0);
    check_eq({tag, "_intr"}, 32'(done_intr), 32'd0);
    check_eq({tag, "_err"}, 32'(err_spurious_done), 32'd0);
    check_eq({tag, "_st0"}, 32'(status_0), 32'(IDLE));
    check_eq({tag, "_st1"}, 32'(status_1), 32'(IDLE));
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    producer = 1'b0;
    idle_inputs();
    #3;
    check_reset_outputs("rst");
    #9 rst = 1'b0;
    step();

    // write-1 group 0 while idle
    drive_write(1'b0, 1'b1);
    step();
    idle_inputs();
    check_eq("w0_d0", 32'(d0_op_en), 32'd1);
    check_eq("w0_op_en_c1", 32'(op_en), 32'd0);
    check_eq("w0_st0_c1", 32'(status_0), 32'(RUN));
    step();
    check_eq("w0_op_en_c2", 32'(op_en), 32'd1);
    check_eq("w0_load_c2", 32'(op_load), 32'd1);
    check_eq("w0_st0_c2", 32'(status_0), 32'(RUN));
    check_eq("w0_st1_c2", 32'(status_1), 32'(IDLE));
    step();
    check_eq("w0_load_c3", 32'(op_load), 32'd0);
    check_eq("w0_op_en_c3", 32'(op_en), 32'd1);

    // enable group 1 -> pending
    drive_write(1'b1, 1'b1);
    step();
    idle_inputs();
    check_eq("w1_d1", 32'(d1_op_en), 32'd1);
    check_eq("w1_st1_pend", 32'(status_1), 32'(PEND));

    // first done: group 0 completes, group 1 runs after a one-cycle gap
    op_done = 1'b1;
    step();
    op_done = 1'b0;
    check_eq("dn0_intr", 32'(done_intr), 32'b01);
    check_eq("dn0_consumer", 32'(consumer), 32'd1);
    check_eq("dn0_op_en", 32'(op_en), 32'd0);
    check_eq("dn0_st0", 32'(status_0), 32'(IDLE));
    check_eq("dn0_st1", 32'(status_1), 32'(RUN));
    check_eq("dn0_d0", 32'(d0_op_en), 32'd0);
    step();
    check_eq("dn0_op_en_t2", 32'(op_en), 32'd1);
    check_eq("dn0_load_t2", 32'(op_load), 32'd1);
    check_eq("dn0_intr_t2", 32'(done_intr), 32'b00);

    // second done: wraps back to group 0, both idle
    op_done = 1'b1;
    step();
    op_done = 1'b0;
    check_eq("dn1_intr", 32'(done_intr), 32'b10);
    check_eq("dn1_consumer", 32'(consumer), 32'd0);
    check_eq("dn1_st0", 32'(status_0), 32'(IDLE));
    check_eq("dn1_st1", 32'(status_1), 32'(IDLE));
    step();
    check_eq("dn1_op_en_t2", 32'(op_en), 32'd0);
    check_eq("dn1_load_t2", 32'(op_load), 32'd0);

    // spurious done
    op_done = 1'b1;
    step();
    op_done = 1'b0;
    check_eq("sp_err", 32'(err_spurious_done), 32'd1);
    check_eq("sp_consumer", 32'(consumer), 32'd0);
    check_eq("sp_d0", 32'(d0_op_en), 32'd0);
    check_eq("sp_d1", 32'(d1_op_en), 32'd0);
    check_eq("sp_intr", 32'(done_intr), 32'b00);
    step();
    step();
    check_eq("sp_err_sticky", 32'(err_spurious_done), 32'd1);

    // write-1 to running group coincident with its done
    drive_write(1'b0, 1'b1);
    step();
    idle_inputs();
    step();
    check_eq("co_op_en", 32'(op_en), 32'd1);
    drive_write(1'b0, 1'b1);
    op_done = 1'b1;
    step();
    idle_inputs();
    check_eq("co_d0", 32'(d0_op_en), 32'd0);
    check_eq("co_consumer", 32'(consumer), 32'd1);
    check_eq("co_intr", 32'(done_intr), 32'b01);

    // write-0 to a pending group is ignored
    drive_write(1'b0, 1'b1);
    step();
    idle_inputs();
    check_eq("pd_st0", 32'(status_0), 32'(PEND));
    drive_write(1'b0, 1'b0);
    step();
    idle_inputs();
    check_eq("w0data_st0", 32'(status_0), 32'(PEND));
    check_eq("w0data_d0", 32'(d0_op_en), 32'd1);
    check_eq("w0data_op_en", 32'(op_en), 32'd0);

    // enable group 1 (the consumer) and reset mid-operation
    drive_write(1'b1, 1'b1);
    step();
    idle_inputs();
    step();
    check_eq("mr_op_en", 32'(op_en), 32'd1);
    check_eq("mr_st1", 32'(status_1), 32'(RUN));
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("arst");
    step();
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("post_rst_intr%0d", i), 32'(done_intr), 32'b00);
      check_eq($sformatf("post_rst_op_en%0d", i), 32'(op_en), 32'd0);
    end

    // simultaneous done on group 0 and write-1 to group 1
    drive_write(1'b0, 1'b1);
    step();
    idle_inputs();
    step();
    check_eq("sim_op_en", 32'(op_en), 32'd1);
    drive_write(1'b1, 1'b1);
    op_done = 1'b1;
    step();
    idle_inputs();
    check_eq("sim_d0", 32'(d0_op_en), 32'd0);
    check_eq("sim_d1", 32'(d1_op_en), 32'd1);
    check_eq("sim_consumer", 32'(consumer), 32'd1);
    check_eq("sim_intr", 32'(done_intr), 32'b01);
    check_eq("sim_op_en_gap", 32'(op_en), 32'd0);
    step();
    check_eq("sim_op_en_t2", 32'(op_en), 32'd1);
    check_eq("sim_load_t2", 32'(op_load), 32'd1);
    check_eq("sim_st1_t2", 32'(status_1), 32'(RUN));
    check_eq("sim_err", 32'(err_spurious_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cdp_rdma_reg_group_ctrl.md
Name: cdp_rdma_reg_group_ctrl

Overview:
- Ping-pong register-group controller for the CDP read DMA.
- Sits between the single-register slice and the RDMA datapath.
  - Consumes the software `producer` pointer and op-enable writes.
  - Tracks two register groups (0/1).
- Produces the `consumer` pointer and per-group status fed back to the single-register slice.
- Drives the operation enable/load handshake and done interrupts toward the datapath.

Parameters:
- IDLE_CODE, 2'd0, status encoding for a group with op_en=0.
- RUN_CODE, 2'd1, status encoding for the enabled group equal to `consumer`.
- PEND_CODE, 2'd2, status encoding for an enabled group not equal to `consumer`.

Ports:
- nvdla_core_clk  in  1  core clock; single clock domain.
- nvdla_core_rst  in  1  asynchronous, active-high reset.
- producer  in  1  software-selected group for programming (from the single-register slice).
- op_en_wr_en  in  1  one-cycle pulse: software write to the op_enable register of group `producer`.
- op_en_wr_data  in  1  bit0 of the write data.
- op_done  in  1  one-cycle pulse from the datapath: current operation finished.
- consumer  out  1  group currently owned by hardware.
- status_0  out  2  state of group 0.
- status_1  out  2  state of group 1.
- d0_op_en  out  1  op_enable flop of group 0 (software readback).
- d1_op_en  out  1  op_enable flop of group 1.
- op_en  out  1  level: datapath may run using group `consumer`.
- op_load  out  1  one-cycle pulse on the first cycle of each op_en assertion.
- done_intr  out  2  one-cycle pulse; bit g = group g completed.
- err_spurious_done  out  1  sticky flag: op_done received while op_en=0.

Behaviour:
- Reset: all flops clear immediately on nvdla_core_rst=1.
  - consumer=0, d0_op_en=d1_op_en=0, op_en=0, op_load=0, done_intr=2'b00, err_spurious_done=0.
  - Both status outputs read IDLE_CODE.
  - Reset mid-operation aborts silently; no done_intr is issued.
- Op-enable write (op_en_wr_en=1):
  - data=1 sets d{producer}_op_en on the next edge.
  - data=0 is ignored; op_en is hardware-cleared only.
  - A write of 1 to an already-set group is a no-op.
- Done (op_done=1 and op_en=1), in one edge:
  - clear d{consumer}_op_en;
  - toggle consumer;
  - done_intr[old consumer]=1 for exactly the next cycle.
- op_done while op_en=0: ignored for state; err_spurious_done<=1 (sticky until reset).
- Simultaneous write-1 to group g and op_done completing group g:
  - the group is already set, so the write is a no-op and done clears it; the result is 0.
- Simultaneous write-1 to the other group and op_done: both take effect in the same edge.
- op_en register: op_en <= d_op_en[consumer] & ~op_done, evaluated with pre-edge values.
  - Done at cycle T gives op_en=0 at T+1.
  - If the new consumer group is enabled, op_en=1 at T+2, a guaranteed one-cycle gap.
  - Write-1 to group `consumer` while idle at cycle T gives d_op_en=1 at T+1 and op_en=1 at T+2.
- op_load: registered, equal to (next op_en) & ~op_en; high in the same cycle op_en first rises, for one cycle.
- Status (combinational from flops), per group g:
  - d{g}_op_en=0 gives IDLE_CODE;
  - else g==consumer gives RUN_CODE;
  - else PEND_CODE.
- Wrap-around: consumer toggles 0→1→0 indefinitely; no counter saturation.
- Back-to-back: both groups enabled gives alternating operations with op_en low exactly one cycle between them.

Decomposition:
- Shared package `cdp_rdma_reg_pkg`:
  - status code constants (IDLE/RUN/PEND);
  - group index typedef (1 bit);
  - status typedef (2 bits).
  - Reusable by the single-register slice.
- One natural sub-module: `cdp_rdma_grp_en`, instantiated twice. It holds a single group's op_enable flop with set (write-1) and clear (done) inputs, plus its status encoding.
- Consumer pointer, op_en/op_load and interrupt logic stay in the top module.

Test Plan:
- Reset release, then write-1 with producer=0 at cycle 0:
  - d0_op_en=1 at cycle 1; op_en=1 and op_load=1 at cycle 2;
  - status_0=RUN_CODE, status_1=IDLE_CODE.
- Both groups enabled; op_done at cycle T:
  - done_intr=2'b01 at T+1; consumer=1 at T+1; op_en=0 at T+1;
  - op_en=1 with op_load=1 at T+2; status_0=IDLE_CODE.
- Group 1 pending (status_1=PEND_CODE), op_done pulse:
  - status_1 becomes RUN_CODE at T+1;
  - a second op_done gives done_intr=2'b10, consumer=0, and both groups IDLE_CODE.
- op_done with op_en=0:
  - err_spurious_done=1 and stays 1; consumer and all op_en flops unchanged.
- Write-1 to running group 0 coincident with its op_done:
  - d0_op_en=0 after the edge; write-0 to a pending group leaves it PEND_CODE.
- Assert nvdla_core_rst while op_en=1:
  - all outputs are at reset values immediately (asynchronous);
  - no done_intr pulse after release.
